// File: rtl/fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// fifo_wr_arbiter
//
// Round-robin write arbiter sharing one synchronous FIFO between NUM_REQ
// producers. A local credit counter mirrors the FIFO free space (stored
// entries plus the write held in the output register), so a grant is only
// issued when the write can never overflow the FIFO.
//
// Ports:
//   clk         single clock, all logic on posedge
//   rst         synchronous active-high reset (the FIFO shares it)
//   req         per-producer write request, held until granted
//   req_data    flattened producer data, slice i = [i*DATA_WIDTH +: DATA_WIDTH]
//   gnt         combinational one-hot grant; data is taken on this edge
//   fifo_wr_en  registered FIFO write strobe (one cycle after grant)
//   fifo_din    registered FIFO write data
//   fifo_rd_en  consumer pop strobe fed back to return a credit
//   fifo_full   FIFO full flag, only used to detect a broken credit mirror
//   credits     current free-entry credit count, 0..DEPTH
//   err         sticky protocol error (credit underflow or FIFO overflow)
// ---------------------------------------------------------------------------
module fifo_wr_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int NUM_REQ    = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            gnt,
    output logic                          fifo_wr_en,
    output logic [DATA_WIDTH-1:0]         fifo_din,
    input  logic                          fifo_rd_en,
    input  logic                          fifo_full,
    output logic [$clog2(DEPTH+1)-1:0]    credits,
    output logic                          err
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [CW-1:0] FULL_CREDITS = CW'(DEPTH);
    localparam logic [CW-1:0] ONE_CREDIT   = CW'(1);

    // Registered state
    logic                  r_wr_en;
    logic [DATA_WIDTH-1:0] r_din;
    logic [CW-1:0]         r_credits;
    logic [PW-1:0]         r_rr_ptr;
    logic                  r_err;

    // Arbitration results
    logic [NUM_REQ-1:0]    w_gnt;
    logic [PW-1:0]         w_gnt_idx;
    logic [PW-1:0]         w_cand;
    logic                  w_any;
    logic [DATA_WIDTH-1:0] w_gnt_data;

    // (base + off) mod NUM_REQ for off < NUM_REQ; NUM_REQ need not be a power of two.
    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] base, input int off);
        int sum;
        sum = int'(base) + off;
        if (sum >= NUM_REQ) begin
            sum = sum - NUM_REQ;
        end
        return PW'(sum);
    endfunction

    // Rotating priority search starting at r_rr_ptr. No grant without a credit
    // and none during reset, so a write is never started that reset would drop.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // through the block leaves it unassigned and infers a latch.
        w_gnt     = '0;
        w_gnt_idx = '0;
        w_cand    = '0;
        w_any     = 1'b0;
        if (!rst && (r_credits != '0)) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                w_cand = wrap_inc(r_rr_ptr, k);
                if (!w_any && req[w_cand]) begin
                    w_gnt[w_cand] = 1'b1;
                    w_gnt_idx     = w_cand;
                    w_any         = 1'b1;
                end
            end
        end
    end

    // Data mux driven by the one-hot grant with constant slice indices.
    always_comb begin
        w_gnt_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_gnt[i]) begin
                w_gnt_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (rst) begin
            r_wr_en   <= 1'b0;
            r_din     <= '0;
            r_credits <= FULL_CREDITS;
            r_rr_ptr  <= '0;
            r_err     <= 1'b0;
        end else begin
            r_wr_en <= w_any;
            if (w_any) begin
                r_din    <= w_gnt_data;
                r_rr_ptr <= wrap_inc(w_gnt_idx, 1);
            end

            // A credit is consumed at grant time, not at the FIFO write, so
            // the write sitting in the output register is already accounted.
            unique case ({w_any, fifo_rd_en})
                2'b10:   r_credits <= r_credits - ONE_CREDIT;
                2'b01: begin
                    if (r_credits != FULL_CREDITS) begin
                        r_credits <= r_credits + ONE_CREDIT;
                    end
                end
                default: r_credits <= r_credits;
            endcase

            // Pop with every credit home means the FIFO was empty; a write into
            // a full FIFO means the mirror is broken. Both latch until reset.
            if (fifo_rd_en && (r_credits == FULL_CREDITS)) begin
                r_err <= 1'b1;
            end
            if (r_wr_en && fifo_full) begin
                r_err <= 1'b1;
            end
        end
    end

    assign gnt        = w_gnt;
    assign fifo_wr_en = r_wr_en;
    assign fifo_din   = r_din;
    assign credits    = r_credits;
    assign err        = r_err;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fifo_wr_arbiter
//
// Self-checking bench for fifo_wr_arbiter (DEPTH=16, NUM_REQ=4, DATA_WIDTH=8).
// A behavioural model (integer credit count, integer pointer, queue standing
// in for the FIFO) predicts every output each cycle. A vector table covers
// round-robin order, wrap/skip and simultaneous grant+pop; hand-written
// sequences cover credit exhaustion, error cases and mid-operation reset;
// a randomized phase runs the model against the DUT.
// ---------------------------------------------------------------------------
module tb_fifo_wr_arbiter;

    localparam int DW      = 8;
    localparam int DEPTH   = 16;
    localparam int NUM_REQ = 4;
    localparam int CW      = $clog2(DEPTH + 1);

    logic                  clk;
    logic                  rst;
    logic [NUM_REQ-1:0]    req;
    logic [NUM_REQ*DW-1:0] req_data;
    logic [NUM_REQ-1:0]    gnt;
    logic                  fifo_wr_en;
    logic [DW-1:0]         fifo_din;
    logic                  fifo_rd_en;
    logic                  fifo_full;
    logic [CW-1:0]         credits;
    logic                  err;

    fifo_wr_arbiter #(
        .DATA_WIDTH(DW),
        .DEPTH     (DEPTH),
        .NUM_REQ   (NUM_REQ)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_data  (req_data),
        .gnt       (gnt),
        .fifo_wr_en(fifo_wr_en),
        .fifo_din  (fifo_din),
        .fifo_rd_en(fifo_rd_en),
        .fifo_full (fifo_full),
        .credits   (credits),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model state
    int            m_credits = DEPTH;
    int            m_ptr     = 0;
    logic          m_wr_en   = 1'b0;
    logic [DW-1:0] m_din     = '0;
    logic          m_err     = 1'b0;
    logic [DW-1:0] fifo_q[$];

    logic [DW-1:0]      pdata[NUM_REQ];
    logic [NUM_REQ-1:0] dut_gnt;
    logic [NUM_REQ-1:0] last_exp_gnt;

    typedef struct {
        logic [NUM_REQ-1:0] req;
        logic               rd;
        logic [NUM_REQ-1:0] gnt;
        int                 credits;
        logic               wr_en;
        logic [DW-1:0]      din;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Rotating-priority choice straight from the rules: first requesting
    // index at or after the pointer, wrapping, only with a credit and no reset.
    function automatic int model_pick(input logic r, input logic [NUM_REQ-1:0] rq);
        if (r || m_credits == 0) return -1;
        for (int k = 0; k < NUM_REQ; k++) begin
            int i;
            i = (m_ptr + k) % NUM_REQ;
            if (rq[i]) return i;
        end
        return -1;
    endfunction

    // One clock cycle: drive on the negedge, check gnt before the posedge,
    // advance the model on the posedge, check registered outputs 1ns later.
    task automatic step(input logic i_rst, input logic [NUM_REQ-1:0] i_req,
                        input logic i_rd, input logic i_force_full);
        int                 pick;
        int                 nxt;
        logic [NUM_REQ-1:0] exp_gnt;
        @(negedge clk);
        rst        = i_rst;
        req        = i_req;
        fifo_rd_en = i_rd;
        fifo_full  = (fifo_q.size() == DEPTH) || i_force_full;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_data[i*DW +: DW] = pdata[i];
        end
        #1;
        pick    = model_pick(i_rst, i_req);
        exp_gnt = (pick < 0) ? '0 : NUM_REQ'(1) << pick;
        dut_gnt = gnt;
        last_exp_gnt = exp_gnt;
        check("gnt", 32'(gnt), 32'(exp_gnt));
        @(posedge clk);
        if (i_rst) begin
            m_wr_en   = 1'b0;
            m_din     = '0;
            m_credits = DEPTH;
            m_ptr     = 0;
            m_err     = 1'b0;
            fifo_q.delete();
        end else begin
            if (m_wr_en && fifo_full) m_err = 1'b1;
            if (i_rd && m_credits == DEPTH) m_err = 1'b1;
            if (i_rd && fifo_q.size() > 0) void'(fifo_q.pop_front());
            if (m_wr_en) fifo_q.push_back(m_din);
            nxt = m_credits - ((pick >= 0) ? 1 : 0) + (i_rd ? 1 : 0);
            m_credits = (nxt > DEPTH) ? DEPTH : nxt;
            if (pick >= 0) begin
                m_wr_en = 1'b1;
                m_din   = pdata[pick];
                m_ptr   = (pick + 1) % NUM_REQ;
            end else begin
                m_wr_en = 1'b0;
            end
        end
        #1;
        check("fifo_wr_en", 32'(fifo_wr_en), 32'(m_wr_en));
        check("fifo_din", 32'(fifo_din), 32'(m_din));
        check("credits", 32'(credits), 32'(m_credits));
        check("err", 32'(err), 32'(m_err));
        if (fifo_wr_en === 1'b0) begin
            check("credit_mirror", 32'(credits), 32'(DEPTH - fifo_q.size()));
        end
    endtask

    initial begin
        int                 grants;
        logic [NUM_REQ-1:0] pending;
        logic [NUM_REQ-1:0] rq;
        logic               rd;

        rst = 1'b1; req = '0; req_data = '0; fifo_rd_en = 1'b0; fifo_full = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) pdata[i] = 8'hA0 + 8'(i);

        // Round robin over all four, then wrap/skip from pointer 3, then
        // grant+pop at 5 credits and a pop-only cycle.
        vecs[0]  = '{4'b1111, 1'b0, 4'b0001, 15, 1'b1, 8'hA0};
        vecs[1]  = '{4'b1111, 1'b0, 4'b0010, 14, 1'b1, 8'hA1};
        vecs[2]  = '{4'b1111, 1'b0, 4'b0100, 13, 1'b1, 8'hA2};
        vecs[3]  = '{4'b1111, 1'b0, 4'b1000, 12, 1'b1, 8'hA3};
        vecs[4]  = '{4'b1111, 1'b0, 4'b0001, 11, 1'b1, 8'hA0};
        vecs[5]  = '{4'b1111, 1'b0, 4'b0010, 10, 1'b1, 8'hA1};
        vecs[6]  = '{4'b1111, 1'b0, 4'b0100,  9, 1'b1, 8'hA2};
        vecs[7]  = '{4'b1111, 1'b0, 4'b1000,  8, 1'b1, 8'hA3};
        vecs[8]  = '{4'b0100, 1'b0, 4'b0100,  7, 1'b1, 8'hA2};
        vecs[9]  = '{4'b0101, 1'b0, 4'b0001,  6, 1'b1, 8'hA0};
        vecs[10] = '{4'b0101, 1'b0, 4'b0100,  5, 1'b1, 8'hA2};
        vecs[11] = '{4'b0101, 1'b1, 4'b0001,  5, 1'b1, 8'hA0};
        vecs[12] = '{4'b0000, 1'b1, 4'b0000,  6, 1'b0, 8'hA0};

        // Reset held two cycles with all requests up
        step(1'b1, 4'b1111, 1'b0, 1'b0);
        step(1'b1, 4'b1111, 1'b0, 1'b0);
        check("rst_gnt", 32'(dut_gnt), 32'd0);
        check("rst_wr_en", 32'(fifo_wr_en), 32'd0);
        check("rst_credits", 32'(credits), 32'd16);
        check("rst_err", 32'(err), 32'd0);

        for (int v = 0; v < 13; v++) begin
            step(1'b0, vecs[v].req, vecs[v].rd, 1'b0);
            check($sformatf("vec%0d_gnt", v), 32'(dut_gnt), 32'(vecs[v].gnt));
            check($sformatf("vec%0d_credits", v), 32'(credits), 32'(vecs[v].credits));
            check($sformatf("vec%0d_wr_en", v), 32'(fifo_wr_en), 32'(vecs[v].wr_en));
            check($sformatf("vec%0d_din", v), 32'(fifo_din), 32'(vecs[v].din));
        end

        // Credit exhaustion: a single producer, no pops
        step(1'b1, 4'b0000, 1'b0, 1'b0);
        grants = 0;
        for (int c = 0; c < 20; c++) begin
            step(1'b0, 4'b0001, 1'b0, 1'b0);
            if (dut_gnt != '0) grants++;
        end
        check("exhaust_grants", 32'(grants), 32'd16);
        check("exhaust_credits", 32'(credits), 32'd0);
        check("exhaust_err", 32'(err), 32'd0);
        // Pop at zero credits: no grant this cycle, one credit back
        step(1'b0, 4'b0001, 1'b1, 1'b0);
        check("pop0_gnt", 32'(dut_gnt), 32'd0);
        check("pop0_credits", 32'(credits), 32'd1);
        step(1'b0, 4'b0001, 1'b0, 1'b0);
        check("regrant_gnt", 32'(dut_gnt), 32'b0001);
        check("regrant_credits", 32'(credits), 32'd0);
        step(1'b0, 4'b0000, 1'b0, 1'b0);

        // Underflow: pop with all credits home
        step(1'b1, 4'b0000, 1'b0, 1'b0);
        step(1'b0, 4'b0000, 1'b1, 1'b0);
        check("uflow_err", 32'(err), 32'd1);
        check("uflow_credits", 32'(credits), 32'd16);
        step(1'b0, 4'b0001, 1'b0, 1'b0);
        check("sticky_err", 32'(err), 32'd1);
        // Reset one cycle after a grant drops the pending write
        step(1'b1, 4'b0000, 1'b0, 1'b0);
        check("midrst_wr_en", 32'(fifo_wr_en), 32'd0);
        check("midrst_credits", 32'(credits), 32'd16);
        check("midrst_err", 32'(err), 32'd0);

        // Overflow: write issued while the FIFO reports full
        step(1'b0, 4'b0001, 1'b0, 1'b0);
        step(1'b0, 4'b0000, 1'b0, 1'b1);
        check("oflow_err", 32'(err), 32'd1);

        // Randomized traffic against the model
        step(1'b1, 4'b0000, 1'b0, 1'b0);
        pending = '0;
        for (int c = 0; c < 400; c++) begin
            rq = pending | NUM_REQ'($urandom_range(0, 15));
            rd = ($urandom_range(0, 2) != 0) && (fifo_q.size() > 0);
            step(($urandom_range(0, 79) == 0), rq, rd, 1'b0);
            pending = rq & ~last_exp_gnt;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (last_exp_gnt[i]) pdata[i] = DW'($urandom);
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
